// File: rtl/ntt_stream_loader.sv
// ntt_stream_loader: packs a word stream into rows for the ntt core, kicks it, then streams the rows back out
module ntt_stream_loader #(
  parameter int LANES    = 257,
  parameter int ROWS     = 85,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  input  logic [5:0]               cmd_mod_idx,
  output logic                     cmd_ready,
  input  logic                     s_valid,
  input  logic [WORD_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     m_valid,
  output logic [WORD_W-1:0]        m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     ntt_start,
  output logic [5:0]               ntt_mod_idx,
  output logic                     ntt_mem_read,
  output logic                     ntt_mem_write,
  output logic [ADDR_W*LANES-1:0]  ntt_mem_addr,
  output logic [WORD_W*LANES-1:0]  ntt_din,
  input  logic [WORD_W*LANES-1:0]  ntt_dout,
  input  logic                     ntt_done,
  output logic                     busy,
  output logic                     job_done,
  output logic                     err
);
  localparam int CW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RCW = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_KICK, S_WAIT, S_RDREQ, S_UNLOAD} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              row_q, row_d, addr_q, addr_d;
  logic [CW-1:0]                  col_q, col_d;
  logic [RCW-1:0]                 rd_cnt_q, rd_cnt_d;
  logic [LANES-1:0][WORD_W-1:0]   row_buf_q, row_buf_d, din_q, din_d;
  logic [5:0]                     mod_q, mod_d;
  logic                           err_q, err_d, done_q, done_d;
  logic                           last_row, last_col;

  assign last_row = row_q == ADDR_W'(ROWS - 1);
  assign last_col = col_q == CW'(LANES - 1);

  assign cmd_ready     = state_q == S_IDLE;
  assign busy          = state_q != S_IDLE;
  assign s_ready       = state_q == S_LOAD;
  assign ntt_mem_write = state_q == S_WRITE;
  assign ntt_start     = state_q == S_KICK;
  assign ntt_mem_read  = state_q == S_RDREQ;
  assign m_valid       = state_q == S_UNLOAD;
  assign m_data        = row_buf_q[col_q];
  assign m_last        = m_valid && last_row && last_col;
  assign job_done      = m_last && m_ready;
  assign ntt_mod_idx   = mod_q;
  assign ntt_mem_addr  = {LANES{addr_q}};
  assign ntt_din       = din_q;
  assign err           = err_q;

  // State register; reset drops any job in flight so no further strobes reach the ntt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      addr_q    <= '0;
      col_q     <= '0;
      rd_cnt_q  <= '0;
      row_buf_q <= '0;
      din_q     <= '0;
      mod_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      rd_cnt_q  <= rd_cnt_d;
      row_buf_q <= row_buf_d;
      din_q     <= din_d;
      mod_q     <= mod_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Job sequencing: load rows, write each, kick, wait for a fresh done edge, read rows back and stream them
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    addr_d    = addr_q;
    col_d     = col_q;
    rd_cnt_d  = rd_cnt_q;
    row_buf_d = row_buf_q;
    din_d     = din_q;
    mod_d     = mod_q;
    err_d     = err_q;
    done_d    = ntt_done;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        mod_d   = cmd_mod_idx;
        err_d   = 1'b0;
        row_d   = '0;
        col_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: if (s_valid) begin
        row_buf_d[col_q] = s_data;
        col_d = col_q + CW'(1);
        err_d = err_q | (s_last != (last_row && last_col));
        if (last_col) begin
          din_d   = row_buf_d;
          addr_d  = row_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        col_d   = '0;
        row_d   = row_q + ADDR_W'(1);
        state_d = last_row ? S_KICK : S_LOAD;
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: if (ntt_done && !done_q) begin
        row_d    = '0;
        addr_d   = '0;
        rd_cnt_d = '0;
        state_d  = S_RDREQ;
      end
      S_RDREQ: begin
        rd_cnt_d = rd_cnt_q + RCW'(1);
        if (rd_cnt_q == RCW'(READ_LAT - 1)) begin
          row_buf_d = ntt_dout;
          col_d     = '0;
          state_d   = S_UNLOAD;
        end
      end
      S_UNLOAD: if (m_ready) begin
        col_d = last_col ? '0 : col_q + CW'(1);
        if (last_col && last_row)
          state_d = S_IDLE;
        else if (last_col) begin
          row_d    = row_q + ADDR_W'(1);
          addr_d   = row_q + ADDR_W'(1);
          rd_cnt_d = '0;
          state_d  = S_RDREQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ntt_stream_loader.sv
// tb_ntt_stream_loader: random jobs through a small loader against a memory-model ntt (dout = din + 1)
module tb_ntt_stream_loader;
  localparam int L = 4, R = 3, W = 32, A = 8, RL = 3, N = L * R;

  logic           clk = 1'b0, reset_n;
  logic           cmd_valid, cmd_ready, s_valid, s_last, s_ready, m_valid, m_last, m_ready;
  logic [5:0]     cmd_mod_idx, ntt_mod_idx;
  logic [W-1:0]   s_data, m_data;
  logic           ntt_start, ntt_mem_read, ntt_mem_write, ntt_done, busy, job_done, err;
  logic [A*L-1:0] ntt_mem_addr;
  logic [W*L-1:0] ntt_din, ntt_dout, dv;

  int vec = 0, miss = 0;
  int wr_tot = 0, wr_base = 0, starts = 0, jobs = 0, rd_cnt = 0, out_idx = 0;
  bit rd_armed = 0, stall_prev = 0;
  logic [W-1:0] stall_data;
  logic         stall_last;
  logic [W-1:0] in_w [N];
  logic [W-1:0] mem [R][L];
  logic [5:0]   cur_mod = '0;

  always #5 clk = ~clk;

  ntt_stream_loader #(.LANES(L), .ROWS(R), .WORD_W(W), .ADDR_W(A), .READ_LAT(RL)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_mod_idx(cmd_mod_idx),
    .cmd_ready(cmd_ready), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .ntt_start(ntt_start), .ntt_mod_idx(ntt_mod_idx),
    .ntt_mem_read(ntt_mem_read), .ntt_mem_write(ntt_mem_write), .ntt_mem_addr(ntt_mem_addr),
    .ntt_din(ntt_din), .ntt_dout(ntt_dout), .ntt_done(ntt_done), .busy(busy),
    .job_done(job_done), .err(err));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [A*L-1:0] rep(input int r);
    for (int k = 0; k < L; k++) rep[k*A +: A] = A'(r);
  endfunction

  // Read data is only valid once mem_read has been held for RL cycles; anything else is poison
  always @(negedge clk) rd_cnt <= ntt_mem_read ? rd_cnt + 1 : 0;

  always_comb begin
    int ra;
    ra = int'(ntt_mem_addr[A-1:0]);
    dv = {L{32'hBAD0BAD0}};
    if (ntt_mem_read && rd_cnt == RL && ra < R)
      for (int k = 0; k < L; k++) dv[k*W +: W] = mem[ra][k] + 32'd1;
  end
  assign ntt_dout = dv;

  // Bus monitor: strobe exclusivity, write/read addressing, row packing, hold-under-backpressure
  always @(negedge clk) begin
    int wi;
    if (!reset_n) stall_prev <= 1'b0;
    else begin
      chk("strobe_onehot", $onehot0({ntt_mem_read, ntt_mem_write, ntt_start}), 1);
      if (busy) chk("mod_idx", ntt_mod_idx, cur_mod);
      if (ntt_mem_write) begin
        wi = wr_tot - wr_base;
        chk("wr_addr", ntt_mem_addr, rep(wi));
        if (wi < R)
          for (int k = 0; k < L; k++) begin
            chk("din_lane", ntt_din[k*W +: W], in_w[wi*L + k]);
            mem[wi][k] <= ntt_din[k*W +: W];
          end
        wr_tot <= wr_tot + 1;
      end
      if (ntt_mem_read) begin
        chk("rd_armed", rd_armed, 1);
        chk("rd_addr", ntt_mem_addr, rep(out_idx / L));
      end
      if (ntt_start) starts <= starts + 1;
      if (job_done) jobs <= jobs + 1;
      if (stall_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, stall_data);
        chk("hold_last", m_last, stall_last);
      end
      stall_prev <= m_valid && !m_ready;
      stall_data <= m_data;
      stall_last <= m_last;
    end
  end

  task automatic run_job(input int bad_pos, input bit drop_last, input bit gaps, input bit bp,
                         input bit stuck, input int abort_at);
    int t, bub, st0, jb0;
    bit bad_seen, want_last;
    for (int i = 0; i < N; i++) in_w[i] = $urandom;
    cur_mod = 6'($urandom);
    wr_base = wr_tot; st0 = starts; jb0 = jobs;
    out_idx = 0; rd_armed = 0; ntt_done = 0; bad_seen = 0;
    @(posedge clk); #1 cmd_valid = 1; cmd_mod_idx = cur_mod;
    @(negedge clk); chk("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 0; cmd_mod_idx = ~cur_mod;
    chk("busy", busy, 1); chk("s_ready_go", s_ready, 1);
    chk("err_cleared", err, 0); chk("mod_latched", ntt_mod_idx, cur_mod);
    bub = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin s_valid = 0; @(posedge clk); #1; end
      want_last = (i == N - 1);
      s_valid = 1; s_data = in_w[i];
      s_last = (i == bad_pos) || (want_last && !drop_last);
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 20) begin t++; @(negedge clk); end
      chk("s_ready", s_ready, 1);
      bub += t;
      bad_seen |= (s_last != want_last);
      @(posedge clk); #1;
      chk("err", err, bad_seen);
    end
    s_valid = 0; s_last = 0;
    if (!gaps) chk("load_bubbles", bub, R - 1);
    if (stuck) ntt_done = 1;
    t = 0;
    @(negedge clk);
    while (!ntt_start && t < 20) begin t++; @(negedge clk); end
    chk("start_seen", ntt_start, 1);
    chk("writes", wr_tot - wr_base, R);
    if (stuck) begin
      repeat (4) @(posedge clk);
      #1 ntt_done = 0;
      repeat (3) @(posedge clk);
      #1 ntt_done = 1;
    end else begin
      repeat (5) @(posedge clk);
      #1 ntt_done = 1;
    end
    rd_armed = 1;
    bub = 0;
    for (int j = 0; j < N; j++) begin
      out_idx = j; t = 0;
      while (t <= 100) begin
        m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (m_valid && m_ready) break;
        if (!m_valid && j > 0) bub++;
        t++;
        @(posedge clk); #1;
      end
      chk("out_hs", m_valid && m_ready, 1);
      chk("m_data", m_data, in_w[j] + 32'd1);
      chk("m_last", m_last, j == N - 1);
      chk("job_done", job_done, j == N - 1);
      if (j == abort_at) begin
        #2 reset_n = 0;
        #1;
        chk("abort_cmd_ready", cmd_ready, 1); chk("abort_busy", busy, 0);
        chk("abort_m_valid", m_valid, 0); chk("abort_m_last", m_last, 0);
        chk("abort_m_data", m_data, 0); chk("abort_read", ntt_mem_read, 0);
        chk("abort_write", ntt_mem_write, 0); chk("abort_start", ntt_start, 0);
        chk("abort_s_ready", s_ready, 0); chk("abort_job_done", job_done, 0);
        chk("abort_err", err, 0); chk("abort_mod", ntt_mod_idx, 0);
        chk("abort_addr", ntt_mem_addr, 0); chk("abort_din", ntt_din, 0);
        m_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        return;
      end
      @(posedge clk); #1;
    end
    m_ready = 0;
    if (!bp) chk("unload_bubbles", bub, (R - 1) * RL);
    chk("cmd_ready_end", cmd_ready, 1);
    chk("job_done_count", jobs - jb0, 1);
    chk("start_count", starts - st0, 1);
    chk("err_end", err, bad_seen);
  endtask

  initial begin
    reset_n = 1; cmd_valid = 0; cmd_mod_idx = 0; s_valid = 0; s_data = 0; s_last = 0;
    m_ready = 0; ntt_done = 0;
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0); chk("rst_m_valid", m_valid, 0);
    chk("rst_strobes", {ntt_start, ntt_mem_read, ntt_mem_write}, 0);
    chk("rst_err", err, 0); chk("rst_job_done", job_done, 0);
    chk("rst_addr", ntt_mem_addr, 0); chk("rst_din", ntt_din, 0);
    chk("rst_m_data", m_data, 0); chk("rst_mod", ntt_mod_idx, 0);
    @(posedge clk); #1 reset_n = 1;
    run_job(-1, 0, 0, 0, 0, -1);
    run_job(-1, 0, 1, 1, 0, -1);
    run_job(5, 0, 1, 0, 0, -1);
    run_job(-1, 1, 0, 0, 0, -1);
    run_job(-1, 0, 0, 0, 1, -1);
    run_job(-1, 0, 0, 1, 0, L + 1);
    run_job(-1, 0, 1, 1, 0, -1);
    repeat (3) run_job(-1, 0, 1, 1, 1'($urandom_range(0, 1)), -1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
